branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Bimodal branch predictor for the picoMIPS pipeline. Produces the registered take-branch prediction (`reg_take_branch`) consumed by the misprediction checker.
- Table of 2-bit saturating counters, indexed by low PC bits, plus one in-flight entry register.
- Lookup happens at fetch. Update happens when the branch resolves in execute, using the actual outcome.

Parameters:
- PC_W, 8, width of program counter.
- IDX_W, 4, table index width; table depth = 2**IDX_W entries, index = pc[IDX_W-1:0].
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  input  1  system clock, rising-edge active.
- nReset  input  1  asynchronous active-low reset.
- lookup_valid  input  1  fetched instruction is a branch; request prediction.
- lookup_pc  input  PC_W  PC of the branch being looked up.
- reg_take_branch  output  1  registered prediction for the in-flight branch (1 = taken).
- pend_valid  output  1  an in-flight branch is awaiting resolution.
- busy  output  1  lookup refused this cycle (combinational).
- resolve_valid  input  1  in-flight branch resolved this cycle.
- branch_actual  input  1  actual outcome of the resolving branch (1 = taken).
- stat_branches  output  16  resolved-branch count (see Optional Feature).
- stat_mispred  output  16  misprediction count (see Optional Feature).

Behaviour:
- Reset (async, nReset=0):
  - All counters = CNT_INIT.
  - reg_take_branch=0, pend_valid=0, pend_idx=0, stats=0.
  - Reset mid-operation discards the in-flight branch; no update occurs.
- Counter encoding:
  - 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Prediction = counter MSB.
- Lookup (latency 1 cycle):
  - Accepted when lookup_valid=1 and (pend_valid=0 or resolve_valid=1).
  - On accept, at the next edge: reg_take_branch <= MSB of counter[lookup_pc[IDX_W-1:0]], pend_idx <= index, pend_valid <= 1.
  - busy = lookup_valid & pend_valid & ~resolve_valid. A refused lookup changes no state; upstream must stall and hold lookup_pc.
- Resolve:
  - Takes effect only when resolve_valid=1 and pend_valid=1.
  - branch_actual=1: counter[pend_idx] saturating-increments (11 stays 11).
  - branch_actual=0: counter[pend_idx] saturating-decrements (00 stays 00).
  - pend_valid <= 0 unless a lookup is accepted in the same cycle.
  - resolve_valid while pend_valid=0 is ignored entirely.
- Hold: reg_take_branch holds its value until the next accepted lookup. It is not cleared on resolve.
- Simultaneous resolve + lookup to the same index: the lookup uses the post-update counter value (bypass). The update and the new capture both occur at the same edge.
- Simultaneous resolve + lookup to a different index: independent; both take effect.
- Only one counter is written per cycle; there is no other write path.

Optional Feature:
- Macro: BPRED_STATS_EN.
- Defined:
  - stat_branches increments on each effective resolve.
  - stat_mispred increments when reg_take_branch != branch_actual on an effective resolve.
  - Both counters saturate at 16'hFFFF.
  - Both are reset to 0 by nReset.
- Undefined: stat_branches and stat_mispred are tied to 0 and no counter flops are built. Predictor behaviour is identical either way.

Test Plan:
- Reset then lookup pc=8'h03 -> next cycle reg_take_branch=0, pend_valid=1. Resolve actual=1 -> counter[3]=10. Lookup pc=8'h13 (aliases index 3) -> reg_take_branch=1.
- Saturation: four consecutive lookup/resolve-taken pairs on pc=8'h05 -> counter[5]=11. Fifth taken resolve -> stays 11. Then two not-taken resolves -> counter[5]=01, next lookup predicts 0.
- Busy: lookup pc=8'h01 accepted; next cycle lookup pc=8'h02 with resolve_valid=0 -> busy=1, reg_take_branch and pend_idx unchanged. Following cycle resolve_valid=1 with the same lookup held -> busy=0, pend_idx=2.
- Bypass: counter[7]=01 in flight; same-cycle resolve actual=1 and lookup pc=8'h07 -> counter[7]=10 and reg_take_branch=1 at that edge.
- Async reset: nReset driven low between clock edges while pend_valid=1 -> pend_valid=0 and reg_take_branch=0 immediately; counters back to 01. Resolve_valid=1 after release -> no counter change.
- With BPRED_STATS_EN: 3 resolves where predicted 0/actual 1, then 2 where predicted 1/actual 1 -> stat_branches=5, stat_mispred=3. Without the macro, both read 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the bimodal branch predictor.
// Upstream drives the lookup and resolve requests; the predictor returns the prediction, busy and stats.
interface branch_predictor_if #(
   parameter int PC_W = 8
);
   logic            lookup_valid;
   logic [PC_W-1:0] lookup_pc;
   logic            reg_take_branch;
   logic            pend_valid;
   logic            busy;
   logic            resolve_valid;
   logic            branch_actual;
   logic [15:0]     stat_branches;
   logic [15:0]     stat_mispred;

   modport master (
      output lookup_valid, lookup_pc, resolve_valid, branch_actual,
      input  reg_take_branch, pend_valid, busy, stat_branches, stat_mispred
   );

   modport slave (
      input  lookup_valid, lookup_pc, resolve_valid, branch_actual,
      output reg_take_branch, pend_valid, busy, stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: 2-bit counters indexed by low PC bits; prediction registered 1 cycle after lookup.
// One branch in flight; busy refuses a lookup until it resolves. Optional counters under BPRED_STATS_EN.
module branch_predictor #(
   parameter int         PC_W     = 8,
   parameter int         IDX_W    = 4,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input logic               clk,
   input logic               nReset,
   branch_predictor_if.slave bp
);
   localparam int DEPTH = 2 ** IDX_W;

   logic [1:0]       cnt_q [DEPTH];
   logic             take_q, take_d;
   logic             pend_valid_q, pend_valid_d;
   logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

   logic [IDX_W-1:0] lk_idx;
   logic             accept;
   logic             resolve_eff;
   logic [1:0]       cnt_cur;
   logic [1:0]       cnt_upd;
   logic [1:0]       lk_cnt;
   logic             unused_pc_hi;

   assign lk_idx       = bp.lookup_pc[IDX_W-1:0];
   assign unused_pc_hi = ^bp.lookup_pc[PC_W-1:IDX_W];

   assign resolve_eff = bp.resolve_valid & pend_valid_q;
   assign accept      = bp.lookup_valid & (~pend_valid_q | bp.resolve_valid);
   assign bp.busy     = bp.lookup_valid & pend_valid_q & ~bp.resolve_valid;

   assign cnt_cur = cnt_q[pend_idx_q];

   always_comb begin
      cnt_upd = cnt_cur;
      if (bp.branch_actual) begin
         if (cnt_cur != 2'b11) cnt_upd = cnt_cur + 2'd1;
      end else begin
         if (cnt_cur != 2'b00) cnt_upd = cnt_cur - 2'd1;
      end
   end

   // A lookup hitting the entry being updated this cycle sees the new value.
   always_comb begin
      lk_cnt = cnt_q[lk_idx];
      if (resolve_eff && (lk_idx == pend_idx_q)) lk_cnt = cnt_upd;
   end

   always_comb begin
      take_d       = take_q;
      pend_idx_d   = pend_idx_q;
      pend_valid_d = pend_valid_q;
      if (resolve_eff) pend_valid_d = 1'b0;
      if (accept) begin
         take_d       = lk_cnt[1];
         pend_idx_d   = lk_idx;
         pend_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
         take_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
      end else begin
         if (resolve_eff) cnt_q[pend_idx_q] <= cnt_upd;
         take_q       <= take_d;
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
      end
   end

   assign bp.reg_take_branch = take_q;
   assign bp.pend_valid      = pend_valid_q;

`ifdef BPRED_STATS_EN
   logic [15:0] stat_br_q, stat_br_d;
   logic [15:0] stat_mp_q, stat_mp_d;

   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (resolve_eff) begin
         if (stat_br_q != 16'hFFFF) stat_br_d = stat_br_q + 16'd1;
         if ((take_q != bp.branch_actual) && (stat_mp_q != 16'hFFFF))
            stat_mp_d = stat_mp_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         stat_br_q <= stat_br_d;
         stat_mp_q <= stat_mp_d;
      end
   end

   assign bp.stat_branches = stat_br_q;
   assign bp.stat_mispred  = stat_mp_q;
`else
   assign bp.stat_branches = '0;
   assign bp.stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor plus hand sequences for reset and stats.
module tb_branch_predictor;
   logic clk;
   logic nReset;
   int   checks;
   int   failures;
   int   model_br;
   int   model_mp;
   logic model_pend;
   logic model_take;

   branch_predictor_if #(.PC_W(8)) bp_if ();

   branch_predictor #(.PC_W(8), .IDX_W(4), .CNT_INIT(2'b01)) dut (
      .clk    (clk),
      .nReset (nReset),
      .bp     (bp_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       lv;
      logic [7:0] pc;
      logic       rv;
      logic       act;
      logic       busy;
      logic       take;
      logic       pend;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic lv, input logic [7:0] pc, input logic rv, input logic act,
                      input logic busy, input logic take, input logic pend);
      vec_t v;
      v.lv = lv; v.pc = pc; v.rv = rv; v.act = act;
      v.busy = busy; v.take = take; v.pend = pend;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic lv, input logic [7:0] pc, input logic rv, input logic act);
      @(negedge clk);
      bp_if.lookup_valid  = lv;
      bp_if.lookup_pc     = pc;
      bp_if.resolve_valid = rv;
      bp_if.branch_actual = act;
   endtask

   task automatic step(input string name, input int idx, input logic lv, input logic [7:0] pc,
                       input logic rv, input logic act, input logic take, input logic pend);
      drive(lv, pc, rv, act);
      @(posedge clk);
      #1;
      chk({name, "_take"}, idx, {15'd0, bp_if.reg_take_branch}, {15'd0, take});
      chk({name, "_pend"}, idx, {15'd0, bp_if.pend_valid}, {15'd0, pend});
   endtask

   initial begin
      checks = 0; failures = 0; model_br = 0; model_mp = 0;
      model_pend = 1'b0; model_take = 1'b0;

      //   lv  pc     rv  act  busy take pend
      add(1, 8'h03, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 1,   0, 0, 0);
      add(1, 8'h13, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 0,   0, 1, 0);
      add(1, 8'h05, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 1,   0, 0, 0);
      add(1, 8'h05, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 1,   0, 1, 0);
      add(1, 8'h05, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 1,   0, 1, 0);
      add(1, 8'h05, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 1,   0, 1, 0);
      add(1, 8'h05, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 1,   0, 1, 0);
      add(1, 8'h05, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 0,   0, 1, 0);
      add(1, 8'h05, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 0,   0, 1, 0);
      add(1, 8'h05, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 0, 0);
      add(1, 8'h05, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 0, 0);
      add(1, 8'h05, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 1,   0, 0, 0);
      add(1, 8'h05, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 1,   0, 0, 0);
      add(1, 8'h05, 0, 0,   0, 1, 1);
      add(0, 8'h00, 1, 0,   0, 1, 0);
      add(1, 8'h02, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 1,   0, 0, 0);
      add(1, 8'h01, 0, 0,   0, 0, 1);
      add(1, 8'h02, 0, 0,   1, 0, 1);
      add(1, 8'h02, 1, 0,   0, 1, 1);
      add(0, 8'h00, 1, 0,   0, 1, 0);
      add(1, 8'h02, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 1,   0, 0, 0);
      add(1, 8'h07, 0, 0,   0, 0, 1);
      add(1, 8'h07, 1, 1,   0, 1, 1);
      add(0, 8'h00, 1, 0,   0, 1, 0);
      add(1, 8'h07, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 0, 0);
      add(1, 8'h09, 0, 0,   0, 0, 1);
      add(1, 8'h0A, 1, 1,   0, 0, 1);
      add(0, 8'h00, 1, 1,   0, 0, 0);
      add(1, 8'h09, 0, 0,   0, 1, 1);
      add(1, 8'h0A, 1, 0,   0, 1, 1);
      add(0, 8'h00, 1, 0,   0, 1, 0);
      add(0, 8'h00, 1, 1,   0, 1, 0);
      add(0, 8'h00, 1, 1,   0, 1, 0);
      add(1, 8'h0A, 0, 0,   0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 0, 0);

      bp_if.lookup_valid = 0; bp_if.lookup_pc = '0;
      bp_if.resolve_valid = 0; bp_if.branch_actual = 0;
      nReset = 1'b0;
      repeat (2) @(negedge clk);
      nReset = 1'b1;
      #1;
      chk("rst_take", 0, {15'd0, bp_if.reg_take_branch}, 16'd0);
      chk("rst_pend", 0, {15'd0, bp_if.pend_valid}, 16'd0);
      chk("rst_busy", 0, {15'd0, bp_if.busy}, 16'd0);
      chk("rst_stat_br", 0, bp_if.stat_branches, 16'd0);
      chk("rst_stat_mp", 0, bp_if.stat_mispred, 16'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].lv, tbl[i].pc, tbl[i].rv, tbl[i].act);
         #1;
         chk("vec_busy", i, {15'd0, bp_if.busy}, {15'd0, tbl[i].busy});
         if (tbl[i].rv && model_pend) begin
            model_br++;
            if (model_take != tbl[i].act) model_mp++;
         end
         @(posedge clk);
         #1;
         chk("vec_take", i, {15'd0, bp_if.reg_take_branch}, {15'd0, tbl[i].take});
         chk("vec_pend", i, {15'd0, bp_if.pend_valid}, {15'd0, tbl[i].pend});
         model_pend = tbl[i].pend;
         model_take = tbl[i].take;
      end

`ifdef BPRED_STATS_EN
      chk("tbl_stat_br", 0, bp_if.stat_branches, 16'(model_br));
      chk("tbl_stat_mp", 0, bp_if.stat_mispred, 16'(model_mp));
`else
      chk("tbl_stat_br", 0, bp_if.stat_branches, 16'd0);
      chk("tbl_stat_mp", 0, bp_if.stat_mispred, 16'd0);
`endif

      // Counter 2 is weakly taken here; put it in flight, then reset between edges.
      step("ar_lk", 0, 1, 8'h02, 0, 0, 1, 1);
      @(negedge clk);
      bp_if.lookup_valid = 0; bp_if.resolve_valid = 0;
      #2 nReset = 1'b0;
      #1;
      chk("ar_take", 0, {15'd0, bp_if.reg_take_branch}, 16'd0);
      chk("ar_pend", 0, {15'd0, bp_if.pend_valid}, 16'd0);
      chk("ar_stat_br", 0, bp_if.stat_branches, 16'd0);
      @(negedge clk);
      nReset = 1'b1;
      step("ar_ign", 0, 0, 8'h00, 1, 1, 0, 0);
      step("ar_lk2", 0, 1, 8'h02, 0, 0, 0, 1);
      step("ar_res", 0, 0, 8'h00, 1, 0, 0, 0);

      step("st", 0, 1, 8'h0B, 0, 0, 0, 1);
      step("st", 1, 0, 8'h00, 1, 1, 0, 0);
      step("st", 2, 1, 8'h0C, 0, 0, 0, 1);
      step("st", 3, 0, 8'h00, 1, 1, 0, 0);
      step("st", 4, 1, 8'h0D, 0, 0, 0, 1);
      step("st", 5, 0, 8'h00, 1, 1, 0, 0);
      step("st", 6, 1, 8'h0B, 0, 0, 1, 1);
      step("st", 7, 0, 8'h00, 1, 1, 1, 0);
      step("st", 8, 1, 8'h0C, 0, 0, 1, 1);
      step("st", 9, 0, 8'h00, 1, 1, 1, 0);
`ifdef BPRED_STATS_EN
      chk("st_branches", 0, bp_if.stat_branches, 16'd6);
      chk("st_mispred", 0, bp_if.stat_mispred, 16'd3);
`else
      chk("st_branches", 0, bp_if.stat_branches, 16'd0);
      chk("st_mispred", 0, bp_if.stat_mispred, 16'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
